ddr_wr_burst_scheduler: RTL and testbench

//  Round-robin scheduler granting the shared DDR AXI write channel to 5 video_sampling write buffers
//  (4 x 1/16 tiles + 9/16 focus view). Per burst it muxes the granted channel, issues AW + 16 W beats,
//  and keeps a per-channel frame write pointer that rewinds on that channel's frame end.

---
 rtl/ddr_wr_burst_scheduler_if.sv | 54 +++++
 rtl/ddr_wr_burst_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_ddr_wr_burst_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_burst_scheduler_if.sv
// Bundle of channel-side and AXI write-side signals around the DDR write
// burst scheduler. The master modport is the scheduler's view; the slave
// modport is the environment's view (write buffers plus DDR controller).
// The optional rd_bank output exists only when FRAME_PINGPONG_EN is defined.
interface ddr_wr_burst_scheduler_if #(
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int CTRL_ADDR_WIDTH = 28
);
    localparam int NCH = 5;
    localparam int DW  = MEM_DQ_WIDTH * 8;

    logic [NCH-1:0]             ch_req;
    logic [NCH-1:0]             ch_frame_end;
    logic [NCH*DW-1:0]          ch_data;
    logic [NCH-1:0]             ch_pop;
    logic [NCH-1:0]             ch_grant;
    logic [NCH-1:0]             frame_done;
    logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
    logic [3:0]                 axi_awlen;
    logic                       axi_awvalid;
    logic                       axi_awready;
    logic [DW-1:0]              axi_wdata;
    logic [MEM_DQ_WIDTH-1:0]    axi_wstrb;
    logic                       axi_wvalid;
    logic                       axi_wready;
    logic                       axi_wlast;
`ifdef FRAME_PINGPONG_EN
    logic [NCH-1:0]             rd_bank;

    modport master (
        input  ch_req, ch_frame_end, ch_data, axi_awready, axi_wready, axi_wlast,
        output ch_pop, ch_grant, frame_done, axi_awaddr, axi_awlen, axi_awvalid,
               axi_wdata, axi_wstrb, axi_wvalid, rd_bank
    );

    modport slave (
        output ch_req, ch_frame_end, ch_data, axi_awready, axi_wready, axi_wlast,
        input  ch_pop, ch_grant, frame_done, axi_awaddr, axi_awlen, axi_awvalid,
               axi_wdata, axi_wstrb, axi_wvalid, rd_bank
    );
`else
    modport master (
        input  ch_req, ch_frame_end, ch_data, axi_awready, axi_wready, axi_wlast,
        output ch_pop, ch_grant, frame_done, axi_awaddr, axi_awlen, axi_awvalid,
               axi_wdata, axi_wstrb, axi_wvalid
    );

    modport slave (
        output ch_req, ch_frame_end, ch_data, axi_awready, axi_wready, axi_wlast,
        input  ch_pop, ch_grant, frame_done, axi_awaddr, axi_awlen, axi_awvalid,
               axi_wdata, axi_wstrb, axi_wvalid
    );
`endif
endinterface

// File: rtl/ddr_wr_burst_scheduler.sv
// Round-robin scheduler sharing one AXI write channel between five video
// write buffers. Each grant issues one AW and up to 16 W beats, then bumps
// that channel's frame write pointer. A frame end rewinds the pointer as
// soon as the channel is not mid-burst (or in the burst's DONE cycle).
// Optional feature macro: FRAME_PINGPONG_EN (two frame banks per channel,
// bank select on address bit CH_ADDR_SHIFT-1, rd_bank output).
module ddr_wr_burst_scheduler #(
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int CH_ADDR_SHIFT   = 22,
    parameter int BURST_ADDR_INC  = 128,
    parameter int FRAME_BURSTS    = 1024
) (
    input  logic                     ddr_clk,
    input  logic                     rst,
    ddr_wr_burst_scheduler_if.master bus
);
    localparam int NCH   = 5;
    localparam int DW    = MEM_DQ_WIDTH * 8;
    localparam int PTR_W = $clog2(FRAME_BURSTS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_AW   = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]                 state_reg;
    logic [2:0]                 last_grant_reg;
    logic [2:0]                 grant_idx_reg;
    logic [NCH-1:0]             grant_reg;
    logic [3:0]                 beat_reg;
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_reg;
    logic [NCH-1:0]             pending_reg;

    logic [NCH-1:0]             pend_eff;
    logic [NCH-1:0]             apply;
    logic [CTRL_ADDR_WIDTH-1:0] ch_addr [NCH];
    logic [DW-1:0]              data_masked [NCH];
    logic [DW-1:0]              wdata_mux;
    logic                       sel_found;
    logic [2:0]                 sel_idx;
    logic                       in_done;
    logic                       beat;

    assign in_done = (state_reg == ST_DONE);
    assign beat    = (state_reg == ST_WR) && bus.axi_wready && rst;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PTR_W-1:0] ptr_reg;
            logic [PTR_W-1:0] ptr_eff;
            logic             bank_eff;

            // A frame end waits while the channel owns the bus, except in DONE
            // where the rewind replaces the normal increment.
            assign pend_eff[gi] = pending_reg[gi] | bus.ch_frame_end[gi];
            assign apply[gi]    = pend_eff[gi] & rst & (~grant_reg[gi] | in_done);
            // A rewind landing in the ARB cycle must already show in the latched address.
            assign ptr_eff      = apply[gi] ? '0 : ptr_reg;

`ifdef FRAME_PINGPONG_EN
            logic bank_reg;

            assign bank_eff       = bank_reg ^ apply[gi];
            assign bus.rd_bank[gi] = ~bank_reg;

            // Each applied frame end swaps the bank being written.
            always_ff @(posedge ddr_clk) begin
                if (!rst)
                    bank_reg <= 1'b0;
                else if (apply[gi])
                    bank_reg <= ~bank_reg;
            end
`else
            assign bank_eff = 1'b0;
`endif

            assign ch_addr[gi] = (CTRL_ADDR_WIDTH'(gi) << CH_ADDR_SHIFT)
                               + (CTRL_ADDR_WIDTH'(ptr_eff) * CTRL_ADDR_WIDTH'(BURST_ADDR_INC))
                               + (CTRL_ADDR_WIDTH'(bank_eff) << (CH_ADDR_SHIFT - 1));

            assign data_masked[gi] = grant_reg[gi] ? bus.ch_data[gi*DW +: DW] : '0;

            // Frame pointer: rewind on applied frame end, else advance after each burst.
            always_ff @(posedge ddr_clk) begin
                if (!rst)
                    ptr_reg <= '0;
                else if (apply[gi])
                    ptr_reg <= '0;
                else if (in_done && grant_reg[gi])
                    ptr_reg <= (ptr_reg == PTR_W'(FRAME_BURSTS - 1)) ? '0 : ptr_reg + PTR_W'(1);
            end
        end
    endgenerate

    // Round-robin pick: first requester after the last owner.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant_reg) + k) % NCH;
            if (!sel_found && bus.ch_req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(idx);
            end
        end
    end

    // Data mux: AND-OR of per-channel slices, zero when nobody is granted.
    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < NCH; i++)
            wdata_mux = wdata_mux | data_masked[i];
    end

    // Frame-end requests stay pending until they can be applied.
    always_ff @(posedge ddr_clk) begin
        if (!rst)
            pending_reg <= '0;
        else
            pending_reg <= pend_eff & ~apply;
    end

    // Burst sequencing: IDLE -> ARB -> AW -> WR -> DONE -> IDLE.
    always_ff @(posedge ddr_clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 3'd4;
            grant_idx_reg  <= '0;
            grant_reg      <= '0;
            beat_reg       <= '0;
            awaddr_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|bus.ch_req)
                        state_reg <= ST_ARB;
                end
                ST_ARB: begin
                    if (sel_found) begin
                        grant_reg     <= {{(NCH-1){1'b0}}, 1'b1} << sel_idx;
                        grant_idx_reg <= sel_idx;
                        awaddr_reg    <= ch_addr[sel_idx];
                        state_reg     <= ST_AW;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (bus.axi_awready) begin
                        beat_reg  <= '0;
                        state_reg <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (beat) begin
                        if (bus.axi_wlast || beat_reg == 4'd15)
                            state_reg <= ST_DONE;
                        else
                            beat_reg <= beat_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    last_grant_reg <= grant_idx_reg;
                    grant_reg      <= '0;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are also gated by reset so an abort stops pops at once.
    assign bus.axi_awvalid = (state_reg == ST_AW) && rst;
    assign bus.axi_wvalid  = (state_reg == ST_WR) && rst;
    assign bus.ch_pop      = beat ? grant_reg : '0;
    assign bus.ch_grant    = grant_reg;
    assign bus.frame_done  = apply;
    assign bus.axi_awaddr  = awaddr_reg;
    assign bus.axi_awlen   = 4'd15;
    assign bus.axi_wstrb   = '1;
    assign bus.axi_wdata   = wdata_mux;

endmodule

// File: tb/tb_ddr_wr_burst_scheduler.sv
// Directed bench for ddr_wr_burst_scheduler: reset state, single-channel
// bursts, strict rotation, wready throttling, AW stall, frame-end rewind,
// pointer wrap and reset abort. Channel buffers are modelled as FWFT
// sources whose data encodes channel index and pop count.
module tb_ddr_wr_burst_scheduler;
    localparam int DW = 256;

`ifdef FRAME_PINGPONG_EN
    localparam logic [27:0] BANK = 28'h0200000;
`else
    localparam logic [27:0] BANK = 28'h0000000;
`endif

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   popcnt [5];

    ddr_wr_burst_scheduler_if #(.MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28)) bus ();

    ddr_wr_burst_scheduler #(
        .MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28), .CH_ADDR_SHIFT(22),
        .BURST_ADDR_INC(128), .FRAME_BURSTS(1024)
    ) dut (
        .ddr_clk (clk),
        .rst     (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] src_data(input int ch, input int cnt);
        logic [31:0] w;
        w = {8'(ch), 24'(cnt)};
        return {8{w}};
    endfunction

    // FWFT source model: each pop advances that channel's data word.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++)
            if (bus.ch_pop[i] === 1'b1)
                popcnt[i] <= popcnt[i] + 1;
    end

    always_comb begin
        bus.ch_data = '0;
        for (int i = 0; i < 5; i++)
            bus.ch_data[i*DW +: DW] = src_data(i, popcnt[i]);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst: wait for AW, check address/grant, then walk the W beats.
    task automatic burst(input string tag, input int ch, input logic [27:0] addr,
                         input int nbeats, input bit toggle, input int fe_ch,
                         input int aw_stall, input int exp_gap);
        int cyc;
        int pops;
        cyc = 0;
        while (bus.axi_awvalid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_awvalid"}, 256'(bus.axi_awvalid), 256'(1));
        if (exp_gap >= 0)
            check({tag, "_gap"}, 256'(cyc), 256'(exp_gap));
        check({tag, "_grant"}, 256'(bus.ch_grant), 256'(1 << ch));
        check({tag, "_awaddr"}, 256'(bus.axi_awaddr), 256'(addr));
        check({tag, "_awlen"}, 256'(bus.axi_awlen), 256'(15));
        if (aw_stall > 0) begin
            bus.axi_awready = 1'b0;
            for (int s = 0; s < aw_stall; s++) begin
                @(negedge clk);
                check({tag, "_aw_hold"}, 256'(bus.axi_awvalid), 256'(1));
                check({tag, "_aw_stable"}, 256'(bus.axi_awaddr), 256'(addr));
            end
            bus.axi_awready = 1'b1;
        end
        @(negedge clk);
        pops = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (bus.axi_wvalid !== 1'b1)
                break;
            bus.axi_wready = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.axi_wlast  = bus.axi_wready && (pops == nbeats - 1);
            if (fe_ch >= 0)
                bus.ch_frame_end = (cyc == 3) ? (5'b00001 << fe_ch) : 5'b00000;
            #1;
            check({tag, "_fd_wr"}, 256'(bus.frame_done), 256'(0));
            if (bus.axi_wready) begin
                check({tag, "_pop"}, 256'(bus.ch_pop), 256'(1 << ch));
                check({tag, "_wdata"}, 256'(bus.axi_wdata), 256'(src_data(ch, popcnt[ch])));
                pops++;
            end else begin
                check({tag, "_nopop"}, 256'(bus.ch_pop), 256'(0));
            end
            @(negedge clk);
        end
        bus.axi_wready   = 1'b1;
        bus.axi_wlast    = 1'b0;
        bus.ch_frame_end = 5'b00000;
        check({tag, "_pops"}, 256'(pops), 256'(nbeats));
        check({tag, "_fd_done"}, 256'(bus.frame_done),
              256'((fe_ch >= 0) ? (1 << fe_ch) : 0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int p0;
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 5; i++) popcnt[i] = 0;
        rst_n            = 1'b0;
        bus.ch_req       = 5'b00000;
        bus.ch_frame_end = 5'b00000;
        bus.axi_awready  = 1'b1;
        bus.axi_wready   = 1'b1;
        bus.axi_wlast    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 256'(bus.ch_grant), 256'(0));
        check("rst_pop", 256'(bus.ch_pop), 256'(0));
        check("rst_fd", 256'(bus.frame_done), 256'(0));
        check("rst_awvalid", 256'(bus.axi_awvalid), 256'(0));
        check("rst_wvalid", 256'(bus.axi_wvalid), 256'(0));
        check("rst_awaddr", 256'(bus.axi_awaddr), 256'(0));
        check("rst_wdata", 256'(bus.axi_wdata), 256'(0));
        check("rst_wstrb", 256'(bus.axi_wstrb), 256'(32'hFFFF_FFFF));
        rst_n = 1'b1;

        // Single channel: two consecutive bursts, pointer advances by 0x80
        bus.ch_req = 5'b00001;
        burst("c0a", 0, 28'h0000000, 16, 1'b0, -1, 0, -1);
        burst("c0b", 0, 28'h0000080, 16, 1'b0, -1, 0, 3);
        bus.ch_req = 5'b00000;

        // Strict rotation with all channels requesting
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.ch_req = 5'b11111;
        burst("rr_a", 0, 28'h0000000, 16, 1'b0, -1, 0, -1);
        burst("rr_b", 1, 28'h0400000, 16, 1'b1, -1, 2, 3);
        burst("rr_c", 2, 28'h0800000, 16, 1'b0, -1, 0, 3);
        burst("rr_d", 3, 28'h0C00000, 16, 1'b0, -1, 0, 3);
        burst("rr_e", 4, 28'h1000000, 16, 1'b0, -1, 0, 3);
        burst("rr_f", 0, 28'h0000080, 16, 1'b0, -1, 0, 3);
        burst("rr_g", 1, 28'h0400080, 16, 1'b0, -1, 0, 3);
        burst("fe_h", 2, 28'h0800080, 16, 1'b0, 2, 0, 3);
        burst("rr_i", 3, 28'h0C00080, 16, 1'b0, -1, 0, 3);
        burst("rr_j", 4, 28'h1000080, 16, 1'b0, -1, 0, 3);
        burst("rr_k", 0, 28'h0000100, 16, 1'b0, -1, 0, 3);
        burst("rr_l", 1, 28'h0400100, 16, 1'b0, -1, 0, 3);
        burst("fe_m", 2, 28'h0800000 | BANK, 16, 1'b0, -1, 0, 3);
        bus.ch_req = 5'b00000;

        // Frame end on an idle channel applies in the same cycle
        @(negedge clk);
        bus.ch_frame_end = 5'b01000;
        #1;
        check("idle_fe", 256'(bus.frame_done), 256'(5'b01000));
`ifdef FRAME_PINGPONG_EN
        check("rd_bank_a", 256'(bus.rd_bank), 256'(5'b11011));
`endif
        @(negedge clk);
        bus.ch_frame_end = 5'b00000;
        #1;
        check("idle_fe_clr", 256'(bus.frame_done), 256'(0));
`ifdef FRAME_PINGPONG_EN
        check("rd_bank_b", 256'(bus.rd_bank), 256'(5'b10011));
`endif
        bus.ch_req = 5'b01000;
        burst("fe_c3", 3, 28'h0C00000 | BANK, 16, 1'b0, -1, 0, -1);
        bus.ch_req = 5'b00000;

        // Reset during beat 7 aborts the burst
        bus.ch_req = 5'b00001;
        cyc = 0;
        while (bus.axi_awvalid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_awaddr", 256'(bus.axi_awaddr), 256'(28'h0000180));
        @(negedge clk);
        p0 = popcnt[0];
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_pop_now", 256'(bus.ch_pop), 256'(0));
        @(negedge clk);
        check("abort_pop", 256'(bus.ch_pop), 256'(0));
        check("abort_wvalid", 256'(bus.axi_wvalid), 256'(0));
        check("abort_awvalid", 256'(bus.axi_awvalid), 256'(0));
        check("abort_grant", 256'(bus.ch_grant), 256'(0));
        check("abort_popcnt", 256'(popcnt[0]), 256'(p0 + 7));
        rst_n = 1'b1;
        burst("abort_rec", 0, 28'h0000000, 16, 1'b0, -1, 0, -1);
        bus.ch_req = 5'b00000;

        // Pointer wrap on channel 1 using single-beat bursts ended by wlast
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.ch_req = 5'b00010;
        for (int k = 0; k < 1024; k++)
            burst("wrap", 1, 28'h0400000 + 28'(k * 128), 1, 1'b0, -1, 0, (k == 0) ? -1 : 3);
        burst("wrap_end", 1, 28'h0400000, 1, 1'b0, -1, 0, 3);
        bus.ch_req = 5'b00000;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
